// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared encodings, states and constants for the md_unit multiply/divide block
package md_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    localparam int MD_ITER = 32;

    localparam logic [31:0] MD_DIV_ZERO_LO = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIN  = 2'b10
    } md_state_e;

    function automatic logic [31:0] md_abs(input logic [31:0] x, input logic neg);
        return neg ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/md_div_step.sv
// rtl/md_div_step.sv - one restoring-division iteration: shift in a dividend bit, trial-subtract the divisor
module md_div_step (
    input  logic [32:0] rem_i,
    input  logic [31:0] divisor_i,
    input  logic        dbit_i,
    output logic [32:0] rem_o,
    output logic        q_o
);

    logic [33:0] shifted;
    logic [33:0] trial;

    assign shifted = {rem_i, dbit_i};
    assign trial   = shifted - {2'b00, divisor_i};

    // A borrow out of the trial subtraction means the divisor did not fit: restore.
    assign q_o   = ~trial[33];
    assign rem_o = q_o ? trial[32:0] : shifted[32:0];

endmodule

// File: rtl/md_unit.sv
// rtl/md_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO; divider datapath present only with MD_DIV_EN
module md_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            hi_we,
    input  logic            lo_we,
    input  logic [XLEN-1:0] wdata,
    output logic            busy,
    output logic            done,
    output logic            div_zero,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    import md_pkg::*;

    md_state_e         state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   ma_q, ma_d;
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic              div_zero_q, div_zero_d;

    logic              op_signed;
    logic              op_is_div;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;

    logic [XLEN:0]     prod_sum;
    logic [2*XLEN-1:0] prod_next;
    logic [2*XLEN-1:0] prod_fix;

    assign op_signed = (op == MD_MULT) || (op == MD_DIV);
    assign op_is_div = (op == MD_DIV) || (op == MD_DIVU);
    assign a_neg     = op_signed & a[XLEN-1];
    assign b_neg     = op_signed & b[XLEN-1];
    assign a_mag     = md_abs(a, a_neg);
    assign b_mag     = md_abs(b, b_neg);

    // Shift-add: multiplier sits in the low half and is consumed LSB first.
    assign prod_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, ma_q} : {(XLEN+1){1'b0}});
    assign prod_next = {prod_sum, prod_q[XLEN-1:1]};
    assign prod_fix  = neg_q ? (~prod_next + 64'd1) : prod_next;

`ifdef MD_DIV_EN
    logic              is_div_q, is_div_d;
    logic              dsgn_q, dsgn_d;
    logic              dz_q, dz_d;
    logic [XLEN:0]     rem_q, rem_d;
    logic [XLEN-1:0]   dq_q, dq_d;

    logic [XLEN:0]     rem_next;
    logic              q_bit;
    logic [XLEN-1:0]   quo_next;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;

    md_div_step u_div_step (
        .rem_i     (rem_q),
        .divisor_i (ma_q),
        .dbit_i    (dq_q[XLEN-1]),
        .rem_o     (rem_next),
        .q_o       (q_bit)
    );

    // dq_q starts as the dividend and fills with quotient bits from the right.
    assign quo_next = {dq_q[XLEN-2:0], q_bit};
    assign quo_fix  = neg_q ? (~quo_next + 32'd1) : quo_next;
    assign rem_fix  = dsgn_q ? (~rem_next[XLEN-1:0] + 32'd1) : rem_next[XLEN-1:0];
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        neg_d      = neg_q;
        ma_d       = ma_q;
        prod_d     = prod_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_zero_d = div_zero_q;
`ifdef MD_DIV_EN
        is_div_d   = is_div_q;
        dsgn_d     = dsgn_q;
        dz_d       = dz_q;
        rem_d      = rem_q;
        dq_d       = dq_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d      = 5'd0;
                    neg_d      = a_neg ^ b_neg;
                    div_zero_d = 1'b0;
                    if (!op_is_div) begin
                        ma_d    = a_mag;
                        prod_d  = {{XLEN{1'b0}}, b_mag};
                        state_d = RUN;
`ifdef MD_DIV_EN
                        is_div_d = 1'b0;
`endif
                    end else begin
`ifdef MD_DIV_EN
                        ma_d     = b_mag;
                        dq_d     = a_mag;
                        rem_d    = {(XLEN+1){1'b0}};
                        dsgn_d   = a_neg;
                        dz_d     = (b == {XLEN{1'b0}});
                        is_div_d = 1'b1;
                        state_d  = RUN;
`else
                        state_d  = FIN;
`endif
                    end
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            RUN: begin
                cnt_d = cnt_q + 5'd1;
`ifdef MD_DIV_EN
                if (is_div_q) begin
                    rem_d = rem_next;
                    dq_d  = quo_next;
                end else begin
                    prod_d = prod_next;
                end
`else
                prod_d = prod_next;
`endif
                if (cnt_q == 5'(MD_ITER - 1)) begin
                    state_d = FIN;
                    cnt_d   = 5'd0;
`ifdef MD_DIV_EN
                    if (is_div_q) begin
                        hi_d       = rem_fix;
                        lo_d       = dz_q ? MD_DIV_ZERO_LO : quo_fix;
                        div_zero_d = dz_q;
                    end else begin
                        hi_d = prod_fix[2*XLEN-1:XLEN];
                        lo_d = prod_fix[XLEN-1:0];
                    end
`else
                    hi_d = prod_fix[2*XLEN-1:XLEN];
                    lo_d = prod_fix[XLEN-1:0];
`endif
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 5'd0;
            neg_q      <= 1'b0;
            ma_q       <= '0;
            prod_q     <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            neg_q      <= neg_d;
            ma_q       <= ma_d;
            prod_q     <= prod_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            div_zero_q <= div_zero_d;
        end
    end

`ifdef MD_DIV_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_div_q <= 1'b0;
            dsgn_q   <= 1'b0;
            dz_q     <= 1'b0;
            rem_q    <= '0;
            dq_q     <= '0;
        end else begin
            is_div_q <= is_div_d;
            dsgn_q   <= dsgn_d;
            dz_q     <= dz_d;
            rem_q    <= rem_d;
            dq_q     <= dq_d;
        end
    end
`endif

    assign busy     = (state_q == RUN) || (state_q == FIN);
    assign done     = (state_q == FIN);
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - directed self-checking bench for md_unit (expectations follow MD_DIV_EN)
module tb_md_unit;

`ifdef MD_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int          total;
    int          bad;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    md_unit #(.XLEN(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .hi_we    (hi_we),
        .lo_we    (lo_we),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one op from IDLE and follow it to completion; divides collapse to a
    // one-cycle no-op when the divider is not built.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] av,
                          input logic [31:0] bv, input logic [31:0] ehi, input logic [31:0] elo,
                          input logic edz);
        int          n;
        int          lat;
        logic [31:0] xhi;
        logic [31:0] xlo;
        logic        xdz;
        if (o[1] && !DIV_EN) begin
            xhi = m_hi;
            xlo = m_lo;
            xdz = 1'b0;
            lat = 1;
        end else begin
            xhi = ehi;
            xlo = elo;
            xdz = edz;
            lat = 33;
        end
        start = 1'b1;
        op    = o;
        a     = av;
        b     = bv;
        @(posedge clk);
        #1;
        start = 1'b0;
        n     = 1;
        chk({tag, ".busy"}, 64'(busy), 64'd1);
        chk({tag, ".hold"}, {hi, lo}, {m_hi, m_lo});
        while (!done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, ".lat"}, 64'(n), 64'(lat));
        chk({tag, ".fin_busy"}, 64'(busy), 64'd1);
        chk({tag, ".hilo"}, {hi, lo}, {xhi, xlo});
        chk({tag, ".dz"}, 64'(div_zero), 64'(xdz));
        @(posedge clk);
        #1;
        chk({tag, ".idle"}, {62'd0, busy, done}, 64'd0);
        m_hi = xhi;
        m_lo = xlo;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        m_hi  = 32'd0;
        m_lo  = 32'd0;
        rst   = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = 32'd0;
        b     = 32'd0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = 32'd0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.done", 64'(done), 64'd0);
        chk("rst.dz", 64'(div_zero), 64'd0);
        chk("rst.hilo", {hi, lo}, 64'd0);
        rst = 1'b0;

        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run_op("div_neg",   2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
        run_op("div_negb",  2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
        run_op("divu_big",  2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 1'b0);
        run_op("divu_zero", 2'b11, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1);
        run_op("mult_min",  2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);

        lo_we = 1'b1;
        wdata = 32'h0000_1234;
        @(posedge clk);
        #1;
        lo_we = 1'b0;
        chk("mtlo.lo", 64'(lo), 64'h1234);
        chk("mtlo.hi", 64'(hi), 64'h4000_0000);
        m_lo = 32'h0000_1234;

        start = 1'b1;
        op    = 2'b01;
        a     = 32'd3;
        b     = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b1;
        op    = 2'b00;
        a     = 32'd9;
        hi_we = 1'b1;
        wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        start = 1'b0;
        hi_we = 1'b0;
        chk("run_ign.hi", 64'(hi), 64'h4000_0000);
        chk("run_ign.busy", 64'(busy), 64'd1);
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst.busy", 64'(busy), 64'd0);
        chk("midrst.done", 64'(done), 64'd0);
        chk("midrst.hilo", {hi, lo}, 64'd0);
        #2;
        rst  = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        run_op("post_rst", 2'b01, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/md_unit.md
# md_unit

Iterative multiply/divide unit for the MIPS CPU's EX stage, sitting beside the ALU. It executes MULT, MULTU, DIV and DIVU over multiple cycles. Results go into architectural HI/LO registers, which MFHI/MFLO read and MTHI/MTLO write. Control stalls the pipeline on `busy` and resumes on `done`.

## Interface
Parameters:
- `XLEN`, 32: operand width; only 32 is supported.

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  request an operation; sampled in IDLE only
- `op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- `a`  in  32  rs operand (multiplicand / dividend)
- `b`  in  32  rt operand (multiplier / divisor)
- `hi_we`  in  1  MTHI write strobe
- `lo_we`  in  1  MTLO write strobe
- `wdata`  in  32  MTHI/MTLO data
- `busy`  out  1  high in RUN and FIN
- `done`  out  1  high for exactly one cycle (FIN)
- `div_zero`  out  1  last completed divide had `b == 0`; valid from FIN until the next accept
- `hi`  out  32  HI register
- `lo`  out  32  LO register

## Operation
- States: IDLE, RUN, FIN.
  - IDLE -> RUN on `start`.
  - RUN -> FIN when the iteration counter reaches 31.
  - FIN -> IDLE unconditionally.
- On accept, the unit latches `op` and the magnitudes of `a` and `b`.
  - Signed ops use |x|.
  - Unsigned ops use x as-is.
  - It also latches the sign of the result and the sign of the dividend.
- Multiply: radix-2 shift-add on a 64-bit accumulator, 32 iterations.
- Divide: restoring division with a 33-bit partial remainder, 32 iterations, one quotient bit per iteration.
- Sign fix, applied on the final RUN edge:
  - Product is negated if the operand signs differ.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
- Results: product goes to {HI, LO}. Quotient goes to LO, remainder to HI.
- Divide by zero: HI = `a` (unmodified dividend), LO = 32'hFFFFFFFF, `div_zero` = 1. Latency is unchanged.
- 0x80000000 / 0xFFFFFFFF (DIV): LO = 0x80000000, HI = 0. No trap, no flag.
- `start` is ignored in RUN and FIN. Nothing is queued.
- MTHI/MTLO:
  - `hi_we`/`lo_we` write `wdata` at the edge, in IDLE only.
  - They are ignored in RUN and FIN.
  - If `start` and a write strobe are both high in IDLE, `start` wins and the write is dropped.
- MULT/MULTU clear `div_zero` at accept.

## Timing
- Reset (asynchronous, any state, including mid-RUN):
  - state = IDLE, counter = 0.
  - `busy` = 0, `done` = 0, `div_zero` = 0, `hi` = 0, `lo` = 0.
  - The in-flight operation is discarded.
- Accepting edge k:
  - `busy` = 1 from cycle k+1.
  - RUN occupies cycles k+1 to k+32.
  - The edge ending cycle k+32 writes HI/LO and `div_zero`.
  - FIN is cycle k+33: `done` = 1, `busy` = 1, and `hi`/`lo` already show the result.
  - IDLE from cycle k+34. The earliest next accept is the edge ending cycle k+34.
- HI/LO hold their old values throughout RUN.
- Latency is fixed at 33 cycles for every op and operand value.

## Configuration
- `MD_DIV_EN` defined: full behaviour as above.
- `MD_DIV_EN` undefined:
  - Divider datapath is removed.
  - DIV/DIVU are still accepted, but go IDLE -> FIN directly: `done` in cycle k+1.
  - HI/LO are unchanged and `div_zero` = 0.
  - Multiply is unaffected.

## Structure
- Shared package `md_pkg`:
  - op encodings `MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU`
  - state enum IDLE/RUN/FIN
  - `MD_ITER = 32`
  - div-by-zero LO constant 32'hFFFFFFFF
- One sub-module, `md_div_step` (combinational, one restoring-division iteration):
  - inputs: 33-bit remainder, 32-bit divisor, incoming dividend bit
  - outputs: next remainder, quotient bit
- The top level contains the FSM, counter, shift-add multiplier, sign fix and HI/LO.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. `done` exactly in cycle k+33, for one cycle.
- MULT a=0xFFFFFFFD (-3), b=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU a=100, b=0 -> HI=0x64, LO=0xFFFFFFFF, `div_zero`=1. A following MULT clears `div_zero`.
- Three cases run in sequence:
  1. MTLO 0x1234 in IDLE -> LO=0x1234.
  2. `start` and `hi_we` pulsed in RUN are ignored.
  3. `rst` asserted at RUN cycle 10 -> immediately `busy`=0, HI=LO=0. A fresh `start` is accepted on the next edge.
